// File: rtl/hazard_forward_unit_if.sv
// Pipeline-side bundle for the hazard/forwarding unit: ID/EX/MEM/WB register info in,
// operand selects and pipeline stall controls out.
interface hazard_forward_unit_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 16
);
    logic [AW-1:0]    id_rs;
    logic [AW-1:0]    id_rt;
    logic             id_uses_rs;
    logic             id_uses_rt;
    logic             idex_memread;
    logic             idex_regwrite;
    logic [AW-1:0]    idex_rd;
    logic [AW-1:0]    ex_rs;
    logic [AW-1:0]    ex_rt;
    logic             exmem_regwrite;
    logic             memwb_regwrite;
    logic [AW-1:0]    exmem_rd;
    logic [AW-1:0]    memwb_rd;
    logic             flush_id;
    logic             clr_stats;
    logic [1:0]       forward_a;
    logic [1:0]       forward_b;
    logic             pc_write;
    logic             ifid_write;
    logic             idex_flush;
    logic             stall_active;
    logic [CNT_W-1:0] stall_cycles;

    modport slave (
        input  id_rs, id_rt, id_uses_rs, id_uses_rt,
        input  idex_memread, idex_regwrite, idex_rd,
        input  ex_rs, ex_rt, exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
        input  flush_id, clr_stats,
        output forward_a, forward_b, pc_write, ifid_write, idex_flush,
        output stall_active, stall_cycles
    );

    modport master (
        output id_rs, id_rt, id_uses_rs, id_uses_rt,
        output idex_memread, idex_regwrite, idex_rd,
        output ex_rs, ex_rt, exmem_regwrite, memwb_regwrite, exmem_rd, memwb_rd,
        output flush_id, clr_stats,
        input  forward_a, forward_b, pc_write, ifid_write, idex_flush,
        input  stall_active, stall_cycles
    );
endinterface

// File: rtl/hazard_forward_unit.sv
// Classic 5-stage forwarding selects plus a load-use stall FSM that holds PC/IF-ID
// for LOAD_LAT cycles per hazard, with a saturating stall-cycle counter.
module hazard_forward_unit #(
    parameter int AW       = 5,
    parameter int LOAD_LAT = 1,
    parameter int CNT_W    = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    hazard_forward_unit_if.slave hz
);
    localparam int               REM_W    = $clog2(8);
    localparam logic [REM_W-1:0] REM_INIT = REM_W'(LOAD_LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state_q;
    logic [REM_W-1:0] rem_q;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] stall_cnt_d;
    logic             hazard;
    logic             stall_now;

    logic [1:0][AW-1:0] ex_src;
    logic [1:0][1:0]    fwd_sel;

    assign ex_src[0] = hz.ex_rs;
    assign ex_src[1] = hz.ex_rt;

    // EX/MEM wins over MEM/WB only when it actually writes; r0 is never a source of data.
    for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
        logic exmem_hit;
        logic memwb_hit;
        assign exmem_hit = hz.exmem_regwrite && (hz.exmem_rd != '0) && (hz.exmem_rd == ex_src[gi]);
        assign memwb_hit = hz.memwb_regwrite && (hz.memwb_rd != '0) && (hz.memwb_rd == ex_src[gi]);
        assign fwd_sel[gi] = !rst_n    ? 2'b00 :
                             exmem_hit ? 2'b10 :
                             memwb_hit ? 2'b01 : 2'b00;
    end

    assign hz.forward_a = fwd_sel[0];
    assign hz.forward_b = fwd_sel[1];

    assign hazard = rst_n & hz.idex_memread & hz.idex_regwrite & (hz.idex_rd != '0) &
                    ((hz.id_uses_rs & (hz.idex_rd == hz.id_rs)) |
                     (hz.id_uses_rt & (hz.idex_rd == hz.id_rt))) &
                    ~hz.flush_id;

    // In STALL the hazard input is irrelevant; a squash releases the pipeline in the same cycle.
    assign stall_now = rst_n & ((state_q == STALL) ? ~hz.flush_id : hazard);

    assign hz.pc_write     = ~stall_now;
    assign hz.ifid_write   = ~stall_now;
    assign hz.idex_flush   = stall_now;
    assign hz.stall_active = rst_n & (state_q == STALL);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= RUN;
            rem_q   <= '0;
        end else begin
            unique case (state_q)
                RUN: begin
                    if (hazard && (LOAD_LAT > 1)) begin
                        state_q <= STALL;
                        rem_q   <= REM_INIT;
                    end
                end
                STALL: begin
                    if (hz.flush_id || (rem_q == REM_W'(1))) begin
                        state_q <= RUN;
                        rem_q   <= '0;
                    end else begin
                        rem_q <= rem_q - REM_W'(1);
                    end
                end
                default: begin
                    state_q <= RUN;
                    rem_q   <= '0;
                end
            endcase
        end
    end

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (hz.clr_stats) begin
            stall_cnt_d = '0;
        end else if (stall_now && (stall_cnt_q != CNT_MAX)) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign hz.stall_cycles = stall_cnt_q;
endmodule

// File: tb/tb_hazard_forward_unit.sv
// Drives three unit instances (LOAD_LAT 1/3/4, CNT_W 16/16/2) with identical pipeline
// stimulus; expectations are queued per step and popped against the outputs.
module tb_hazard_forward_unit;
    localparam logic [7:0] IDLE   = 8'h0C;  // fa=00 fb=00 pc=1 ifid=1 flush=0 active=0
    localparam logic [7:0] HZ_RUN = 8'h02;  // hazard seen in RUN
    localparam logic [7:0] HZ_ST  = 8'h03;  // held in STALL
    localparam logic [7:0] FL_ST  = 8'h0D;  // squash while in STALL

    typedef struct {
        string       tag;
        int          dut;
        int          kind;
        logic [31:0] val;
    } exp_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_fail;
    exp_t sb_q[$];

    hazard_forward_unit_if #(.AW(5), .CNT_W(16)) ifa ();
    hazard_forward_unit_if #(.AW(5), .CNT_W(16)) ifb ();
    hazard_forward_unit_if #(.AW(5), .CNT_W(2))  ifc ();

    hazard_forward_unit #(.AW(5), .LOAD_LAT(1), .CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .hz(ifa));
    hazard_forward_unit #(.AW(5), .LOAD_LAT(3), .CNT_W(16)) dut_b (.clk(clk), .rst_n(rst_n), .hz(ifb));
    hazard_forward_unit #(.AW(5), .LOAD_LAT(4), .CNT_W(2))  dut_c (.clk(clk), .rst_n(rst_n), .hz(ifc));

    always_comb begin
        ifb.id_rs          = ifa.id_rs;          ifc.id_rs          = ifa.id_rs;
        ifb.id_rt          = ifa.id_rt;          ifc.id_rt          = ifa.id_rt;
        ifb.id_uses_rs     = ifa.id_uses_rs;     ifc.id_uses_rs     = ifa.id_uses_rs;
        ifb.id_uses_rt     = ifa.id_uses_rt;     ifc.id_uses_rt     = ifa.id_uses_rt;
        ifb.idex_memread   = ifa.idex_memread;   ifc.idex_memread   = ifa.idex_memread;
        ifb.idex_regwrite  = ifa.idex_regwrite;  ifc.idex_regwrite  = ifa.idex_regwrite;
        ifb.idex_rd        = ifa.idex_rd;        ifc.idex_rd        = ifa.idex_rd;
        ifb.ex_rs          = ifa.ex_rs;          ifc.ex_rs          = ifa.ex_rs;
        ifb.ex_rt          = ifa.ex_rt;          ifc.ex_rt          = ifa.ex_rt;
        ifb.exmem_regwrite = ifa.exmem_regwrite; ifc.exmem_regwrite = ifa.exmem_regwrite;
        ifb.memwb_regwrite = ifa.memwb_regwrite; ifc.memwb_regwrite = ifa.memwb_regwrite;
        ifb.exmem_rd       = ifa.exmem_rd;       ifc.exmem_rd       = ifa.exmem_rd;
        ifb.memwb_rd       = ifa.memwb_rd;       ifc.memwb_rd       = ifa.memwb_rd;
        ifb.flush_id       = ifa.flush_id;       ifc.flush_id       = ifa.flush_id;
        ifb.clr_stats      = ifa.clr_stats;      ifc.clr_stats      = ifa.clr_stats;
    end

    logic [7:0] wa, wb, wc;
    assign wa = {ifa.forward_a, ifa.forward_b, ifa.pc_write, ifa.ifid_write, ifa.idex_flush, ifa.stall_active};
    assign wb = {ifb.forward_a, ifb.forward_b, ifb.pc_write, ifb.ifid_write, ifb.idex_flush, ifb.stall_active};
    assign wc = {ifc.forward_a, ifc.forward_b, ifc.pc_write, ifc.ifid_write, ifc.idex_flush, ifc.stall_active};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] observe(input int dut, input int kind);
        logic [31:0] r;
        r = '0;
        case (dut)
            0:       r = (kind == 0) ? 32'(wa) : 32'(ifa.stall_cycles);
            1:       r = (kind == 0) ? 32'(wb) : 32'(ifb.stall_cycles);
            default: r = (kind == 0) ? 32'(wc) : 32'(ifc.stall_cycles);
        endcase
        return r;
    endfunction

    task automatic push(input string tag, input int dut, input int kind, input logic [31:0] v);
        exp_t e;
        e.tag  = tag;
        e.dut  = dut;
        e.kind = kind;
        e.val  = v;
        sb_q.push_back(e);
    endtask

    task automatic check_all();
        exp_t        e;
        logic [31:0] obs;
        while (sb_q.size() > 0) begin
            e   = sb_q.pop_front();
            obs = observe(e.dut, e.kind);
            n_cmp++;
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s dut%0d %s observed=%0h expected=%0h", e.tag, e.dut,
                       (e.kind == 0) ? "outs" : "stall_cycles", obs, e.val);
            end
        end
    endtask

    // Queue expectations for the inputs just driven, let them settle, then compare.
    task automatic run(input string tag, input logic [7:0] ea, input logic [7:0] eb,
                       input logic [7:0] ec, input int ca, input int cb, input int cc);
        push(tag, 0, 0, 32'(ea));
        push(tag, 1, 0, 32'(eb));
        push(tag, 2, 0, 32'(ec));
        push(tag, 0, 1, 32'(ca));
        push(tag, 1, 1, 32'(cb));
        push(tag, 2, 1, 32'(cc));
        #1;
        check_all();
        $display("step %-10s outs=%h/%h/%h cnt=%0d/%0d/%0d", tag, wa, wb, wc,
                 ifa.stall_cycles, ifb.stall_cycles, ifc.stall_cycles);
    endtask

    task automatic clear_in();
        ifa.id_rs = '0;          ifa.id_rt = '0;
        ifa.id_uses_rs = 1'b0;   ifa.id_uses_rt = 1'b0;
        ifa.idex_memread = 1'b0; ifa.idex_regwrite = 1'b0; ifa.idex_rd = '0;
        ifa.ex_rs = '0;          ifa.ex_rt = '0;
        ifa.exmem_regwrite = 1'b0; ifa.memwb_regwrite = 1'b0;
        ifa.exmem_rd = '0;       ifa.memwb_rd = '0;
        ifa.flush_id = 1'b0;     ifa.clr_stats = 1'b0;
    endtask

    task automatic load_use_rs();
        ifa.idex_memread = 1'b1; ifa.idex_regwrite = 1'b1; ifa.idex_rd = 5'd5;
        ifa.id_rs = 5'd5;        ifa.id_uses_rs = 1'b1;
    endtask

    initial begin
        n_cmp  = 0;
        n_fail = 0;
        rst_n  = 1'b0;
        clear_in();

        // Reset dominates matching forward and hazard inputs.
        @(negedge clk); load_use_rs();
        ifa.exmem_regwrite = 1'b1; ifa.exmem_rd = 5'd3; ifa.ex_rs = 5'd3;
        run("reset", IDLE, IDLE, IDLE, 0, 0, 0);

        @(negedge clk); rst_n = 1'b1; clear_in();
        run("idle", IDLE, IDLE, IDLE, 0, 0, 0);

        @(negedge clk); clear_in();
        ifa.exmem_regwrite = 1'b1; ifa.memwb_regwrite = 1'b1;
        ifa.exmem_rd = 5'd3; ifa.memwb_rd = 5'd3; ifa.ex_rs = 5'd3; ifa.ex_rt = 5'd4;
        run("fwd_exmem", 8'h8C, 8'h8C, 8'h8C, 0, 0, 0);

        @(negedge clk); clear_in();
        ifa.exmem_regwrite = 1'b0; ifa.memwb_regwrite = 1'b1;
        ifa.exmem_rd = 5'd3; ifa.memwb_rd = 5'd3; ifa.ex_rs = 5'd3; ifa.ex_rt = 5'd3;
        run("fwd_memwb", 8'h5C, 8'h5C, 8'h5C, 0, 0, 0);

        @(negedge clk); clear_in();
        ifa.exmem_regwrite = 1'b1; ifa.memwb_regwrite = 1'b1;
        ifa.exmem_rd = 5'd4; ifa.memwb_rd = 5'd3; ifa.ex_rs = 5'd3; ifa.ex_rt = 5'd4;
        run("fwd_mixed", 8'h6C, 8'h6C, 8'h6C, 0, 0, 0);

        // r0 never forwards, and a load to r0 never stalls.
        @(negedge clk); clear_in();
        ifa.exmem_regwrite = 1'b1; ifa.memwb_regwrite = 1'b1;
        ifa.idex_memread = 1'b1; ifa.idex_regwrite = 1'b1; ifa.id_uses_rs = 1'b1;
        run("r0", IDLE, IDLE, IDLE, 0, 0, 0);

        @(negedge clk); load_use_rs(); ifa.id_uses_rs = 1'b0;
        run("no_use", IDLE, IDLE, IDLE, 0, 0, 0);

        // Single load-use hazard: 1, 3 and 4 stalled cycles respectively.
        @(negedge clk); clear_in(); load_use_rs();
        run("hz1", HZ_RUN, HZ_RUN, HZ_RUN, 0, 0, 0);
        @(negedge clk); clear_in();
        run("st2", IDLE, HZ_ST, HZ_ST, 1, 1, 1);
        @(negedge clk); clear_in();
        run("st3", IDLE, HZ_ST, HZ_ST, 1, 2, 2);
        @(negedge clk); clear_in();
        run("st4", IDLE, IDLE, HZ_ST, 1, 3, 3);
        @(negedge clk); clear_in();
        run("st5", IDLE, IDLE, IDLE, 1, 3, 3);
        @(negedge clk); clear_in(); ifa.clr_stats = 1'b1;
        run("clr", IDLE, IDLE, IDLE, 1, 3, 3);
        @(negedge clk); clear_in();
        run("clr_chk", IDLE, IDLE, IDLE, 0, 0, 0);

        // Squash on the second stalled cycle releases immediately.
        @(negedge clk); clear_in(); load_use_rs();
        run("hz_f", HZ_RUN, HZ_RUN, HZ_RUN, 0, 0, 0);
        @(negedge clk); clear_in(); load_use_rs(); ifa.flush_id = 1'b1;
        run("flush", IDLE, FL_ST, FL_ST, 1, 1, 1);
        @(negedge clk); clear_in();
        run("post_fl", IDLE, IDLE, IDLE, 1, 1, 1);

        // Hazard held during STALL is ignored; then asynchronous reset mid-stall.
        @(negedge clk); clear_in(); load_use_rs();
        run("hz_r", HZ_RUN, HZ_RUN, HZ_RUN, 1, 1, 1);
        @(negedge clk); clear_in(); load_use_rs();
        run("ign", HZ_RUN, HZ_ST, HZ_ST, 2, 2, 2);
        @(negedge clk); clear_in();
        run("pre_rst", IDLE, HZ_ST, HZ_ST, 3, 3, 3);
        #2 rst_n = 1'b0;
        run("rst_mid", IDLE, IDLE, IDLE, 0, 0, 0);
        @(negedge clk); rst_n = 1'b1; clear_in();
        run("rst_rel", IDLE, IDLE, IDLE, 0, 0, 0);

        // Five stalled cycles saturate the 2-bit counter; clear beats a stall cycle.
        @(negedge clk); clear_in(); load_use_rs();
        run("s1", HZ_RUN, HZ_RUN, HZ_RUN, 0, 0, 0);
        @(negedge clk); clear_in();
        run("s2", IDLE, HZ_ST, HZ_ST, 1, 1, 1);
        @(negedge clk); clear_in();
        run("s3", IDLE, HZ_ST, HZ_ST, 1, 2, 2);
        @(negedge clk); clear_in();
        run("s4", IDLE, IDLE, HZ_ST, 1, 3, 3);
        @(negedge clk); clear_in();
        ifa.idex_memread = 1'b1; ifa.idex_regwrite = 1'b1; ifa.idex_rd = 5'd7;
        ifa.id_rt = 5'd7; ifa.id_uses_rt = 1'b1;
        run("s5_rt", HZ_RUN, HZ_RUN, HZ_RUN, 1, 3, 3);
        @(negedge clk); clear_in(); ifa.clr_stats = 1'b1;
        run("s6_clr", IDLE, HZ_ST, HZ_ST, 2, 4, 3);
        @(negedge clk); clear_in();
        run("s7", IDLE, HZ_ST, HZ_ST, 0, 0, 0);
        @(negedge clk); clear_in();
        run("s8", IDLE, IDLE, HZ_ST, 0, 1, 1);
        @(negedge clk); clear_in();
        run("s9", IDLE, IDLE, IDLE, 0, 1, 2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule

// File: doc/hazard_forward_unit.md
HAZARD_FORWARD_UNIT -- requirements
Module: hazard_forward_unit

Interface
REQ-001 The block SHALL take parameter AW, default 5, as the register-address width.
REQ-002 The block SHALL take parameter LOAD_LAT, default 1, legal 1..8, as the number of bubble cycles a load-use hazard costs.
REQ-003 The block SHALL take parameter CNT_W, default 16, as the stall-statistics counter width.
REQ-004 The block SHALL have one clock and an asynchronous active-low reset:
- clk  in  1  rising-edge clock.
- rst_n  in  1  asynchronous active-low reset.
REQ-005 The block SHALL have these ports:
- id_rs, id_rt  in  AW  source registers of the instruction in ID.
- id_uses_rs, id_uses_rt  in  1  ID instruction reads rs/rt.
- idex_memread, idex_regwrite  in  1  EX-stage instruction is a load / writes a register.
- idex_rd  in  AW  EX-stage destination.
- ex_rs, ex_rt  in  AW  EX-stage source registers.
- exmem_regwrite, memwb_regwrite  in  1  write enables of the EX/MEM and MEM/WB stages.
- exmem_rd, memwb_rd  in  AW  destinations of the EX/MEM and MEM/WB stages.
- flush_id  in  1  ID instruction squashed this cycle (taken branch).
- clr_stats  in  1  synchronous clear of stall_cycles.
- forward_a, forward_b  out  2  ALU operand select: 00 regfile, 10 EX/MEM, 01 MEM/WB.
- pc_write, ifid_write  out  1  PC / IF-ID register update enable.
- idex_flush  out  1  insert a bubble into ID/EX.
- stall_active  out  1  FSM is in STALL.
- stall_cycles  out  CNT_W  saturating count of cycles with pc_write=0.

Function
REQ-006 forward_a SHALL be 10 when exmem_regwrite=1, exmem_rd!=0 and exmem_rd==ex_rs; otherwise 01 when memwb_regwrite=1, memwb_rd!=0 and memwb_rd==ex_rs; otherwise 00 (combinational).
REQ-007 forward_b SHALL follow REQ-006 with ex_rt in place of ex_rs.
REQ-008 An EX/MEM entry that matches but has exmem_regwrite=0 SHALL NOT block an MEM/WB match.
REQ-009 Register 0 SHALL never be forwarded and SHALL never cause a hazard.
REQ-010 hazard SHALL equal idex_memread & idex_regwrite & (idex_rd!=0) & ((id_uses_rs & idex_rd==id_rs) | (id_uses_rt & idex_rd==id_rt)) & ~flush_id.
REQ-011 The FSM SHALL have two states: RUN and STALL, with an internal down-counter rem of width ceil(log2(8)).
REQ-012 In RUN with hazard=1, the block SHALL drive pc_write=0, ifid_write=0 and idex_flush=1 in the same cycle.
REQ-013 In the case of REQ-012 with LOAD_LAT>1, the FSM SHALL go to STALL with rem=LOAD_LAT-1; with LOAD_LAT=1 it SHALL stay in RUN.
REQ-014 In STALL, the block SHALL drive pc_write=0, ifid_write=0, idex_flush=1 and stall_active=1, and decrement rem each cycle.
REQ-015 The FSM SHALL leave STALL for RUN at the edge where rem==1, giving exactly LOAD_LAT stalled cycles per hazard.
REQ-016 hazard SHALL be ignored while in STALL.
REQ-017 flush_id=1 in STALL SHALL force RUN at the next edge.
REQ-018 In the cycle of REQ-017, the block SHALL drive pc_write=1, ifid_write=1 and idex_flush=0.
REQ-019 In RUN with hazard=0, the block SHALL drive pc_write=1, ifid_write=1, idex_flush=0 and stall_active=0.
REQ-020 stall_cycles SHALL increment by 1 each edge at which pc_write=0 and SHALL saturate at 2^CNT_W-1.
REQ-021 clr_stats=1 SHALL load stall_cycles with 0 and SHALL take priority over increment.

Reset
REQ-022 While rst_n=0, the block SHALL hold state=RUN, rem=0 and stall_cycles=0.
REQ-023 While rst_n=0, the block SHALL drive pc_write=1, ifid_write=1, idex_flush=0, stall_active=0 and forward_a=forward_b=00, regardless of other inputs.
REQ-024 Assertion of rst_n mid-stall SHALL abort the stall immediately, without waiting for a clock edge.

Verification
REQ-025 exmem_regwrite=memwb_regwrite=1, exmem_rd=memwb_rd=3, ex_rs=3 -> forward_a=10; then exmem_regwrite=0 -> forward_a=01.
REQ-026 exmem_regwrite=1, exmem_rd=0, ex_rs=ex_rt=0 -> forward_a=forward_b=00; load to r0 followed by a reader of r0 -> no stall.
REQ-027 LOAD_LAT=1, load r5 in EX, ID reads r5 -> exactly 1 cycle with pc_write=0 and idex_flush=1, stall_active stays 0, stall_cycles=1.
REQ-028 LOAD_LAT=3, same stimulus as REQ-027 -> 3 consecutive stalled cycles, stall_active=1 on cycles 2-3, stall_cycles=3, then pc_write=1.
REQ-029 LOAD_LAT=4, flush_id=1 on the 2nd stalled cycle -> RUN at the next edge and pc_write=1; separately, rst_n=0 mid-stall -> outputs at reset values before the next edge.
REQ-030 CNT_W=2 with 5 stalled cycles -> stall_cycles=3; clr_stats=1 coincident with a stall cycle -> stall_cycles=0.
